// File: rtl/jtcop_snd_map.sv
// rtl/jtcop_snd_map.sv - sound CPU chip-select decoder with rotating page map and read-data mux
// Device pages move through NST map states; advance/clear pages step or reset the map.
module jtcop_snd_map #(
    parameter int                          PW        = 5,
    parameter int                          NDEV      = 4,
    parameter int                          STW       = 2,
    parameter logic [(2**STW)*NDEV*PW-1:0] MAP       = {
        5'h1E, 5'h1F, 5'h19, 5'h1C,
        5'h11, 5'h13, 5'h17, 5'h14,
        5'h0C, 5'h09, 5'h0F, 5'h0E,
        5'h07, 5'h06, 5'h01, 5'h03 },
    parameter logic [PW-1:0]               ROM_PAGE  = 5'h00,
    parameter logic [PW-1:0]               RAM_PAGE  = 5'h1F,
    parameter logic [PW-1:0]               ADV_PAGE  = 5'h02,
    parameter logic [PW-1:0]               CLR_PAGE  = 5'h03,
    parameter bit                          ADV_ON_WR = 1'b0,
    parameter bit                          ROT_EN    = 1'b1,
    parameter bit                          ROM_SWZ   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sx,
    input  logic                 ce,
    input  logic [PW-1:0]        page,
    input  logic                 wrn,
    input  logic                 rom_ok,
    input  logic [7:0]           rom_data,
    input  logic [7:0]           ram_dout,
    input  logic [NDEV*8-1:0]    dev_dout,
    output logic                 rom_cs,
    output logic                 ram_cs,
    output logic [NDEV-1:0]      dev_cs,
    output logic [7:0]           din,
    output logic                 wait_n,
    output logic [STW-1:0]       map_st
);

    logic            adv_hit;
    logic            clr_hit;
    logic            adv_l;
    logic            clr_l;
    logic [NDEV-1:0] dev_match;
    logic [7:0]      rom_byte;
    logic [7:0]      din_mux;

    // Decode against the map state present at the sx edge.
    always_comb begin
        dev_match = '0;
        for (int d = 0; d < NDEV; d++) begin
            dev_match[d] = (page == MAP[(int'(map_st) * NDEV + d) * PW +: PW]);
        end
    end

    assign rom_byte = ROM_SWZ ? {rom_data[0], rom_data[6:1], rom_data[7]} : rom_data;

    // Descending scan so the lowest-index active device wins.
    always_comb begin
        din_mux = 8'hFF;
        if (rom_cs) begin
            din_mux = rom_byte;
        end
        for (int d = NDEV - 1; d >= 0; d--) begin
            if (dev_cs[d]) begin
                din_mux = dev_dout[d*8 +: 8];
            end
        end
        if (ram_cs) begin
            din_mux = ram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs  <= 1'b0;
            ram_cs  <= 1'b0;
            dev_cs  <= '0;
            adv_hit <= 1'b0;
            clr_hit <= 1'b0;
            adv_l   <= 1'b0;
            clr_l   <= 1'b0;
            map_st  <= '0;
            din     <= 8'hFF;
            wait_n  <= 1'b1;
        end else begin
            if (sx) begin
                rom_cs  <= (page == ROM_PAGE);
                ram_cs  <= (page == RAM_PAGE);
                dev_cs  <= dev_match;
                adv_hit <= (page == ADV_PAGE) && (!ADV_ON_WR || !wrn);
                clr_hit <= (page == CLR_PAGE);
            end else if (ce) begin
                rom_cs  <= 1'b0;
                ram_cs  <= 1'b0;
                dev_cs  <= '0;
                adv_hit <= 1'b0;
                clr_hit <= 1'b0;
            end

            // Edge detection gives exactly one step per bus cycle.
            adv_l <= adv_hit;
            clr_l <= clr_hit;
            if (!ROT_EN) begin
                map_st <= '0;
            end else if (clr_hit && !clr_l) begin
                map_st <= '0;
            end else if (adv_hit && !adv_l) begin
                map_st <= map_st + 1'b1;
            end

            din    <= din_mux;
            wait_n <= !rom_cs || rom_ok;
        end
    end

endmodule

// File: tb/tb_jtcop_snd_map.sv
// tb/tb_jtcop_snd_map.sv - scoreboard bench for jtcop_snd_map across four parameter builds
// Build 0 default, 1 write-only advance + raw ROM, 2 rotation off, 3 advance page == clear page.
module tb_jtcop_snd_map;

    typedef struct packed {
        logic       rom;
        logic       ram;
        logic [3:0] dev;
        logic [7:0] din;
        logic [1:0] st;
    } res_t;

    typedef struct packed {
        res_t [3:0] r;
        logic [7:0] lows;
    } exp_t;

    localparam bit         ADVW [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit         ROTE [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    localparam bit         SWZ  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [4:0] CLRP [4] = '{5'h03, 5'h03, 5'h03, 5'h02};
    localparam logic [4:0] TBL [4][4] = '{
        '{5'h03, 5'h01, 5'h06, 5'h07},
        '{5'h0E, 5'h0F, 5'h09, 5'h0C},
        '{5'h14, 5'h17, 5'h13, 5'h11},
        '{5'h1C, 5'h19, 5'h1F, 5'h1E}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sx = 1'b0;
    logic        ce = 1'b0;
    logic        wrn = 1'b1;
    logic        rom_ok = 1'b1;
    logic [4:0]  page = '0;
    logic [7:0]  rom_data = '0;
    logic [7:0]  ram_dout = '0;
    logic [31:0] dev_dout = '0;

    logic        rom_cs_o [4];
    logic        ram_cs_o [4];
    logic [3:0]  dev_cs_o [4];
    logic [7:0]  din_o    [4];
    logic        wait_o   [4];
    logic [1:0]  st_o     [4];

    int   checks = 0;
    int   failures = 0;
    int   mst [4];
    bit   mon_en = 1'b0;
    exp_t expq [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        jtcop_snd_map #(
            .CLR_PAGE  (CLRP[g]),
            .ADV_ON_WR (ADVW[g]),
            .ROT_EN    (ROTE[g]),
            .ROM_SWZ   (SWZ[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .sx       (sx),
            .ce       (ce),
            .page     (page),
            .wrn      (wrn),
            .rom_ok   (rom_ok),
            .rom_data (rom_data),
            .ram_dout (ram_dout),
            .dev_dout (dev_dout),
            .rom_cs   (rom_cs_o[g]),
            .ram_cs   (ram_cs_o[g]),
            .dev_cs   (dev_cs_o[g]),
            .din      (din_o[g]),
            .wait_n   (wait_o[g]),
            .map_st   (st_o[g])
        );
    end

    task automatic chk(input string nm, input int g, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", nm, g, act, req);
        end
    endtask

    // Reference: decode with the state before the access, then apply clear/advance.
    task automatic model(input int g, input logic [4:0] pg, input logic wr_n, output res_t r);
        logic [7:0] rb;
        r.rom = (pg == 5'h00);
        r.ram = (pg == 5'h1F);
        for (int d = 0; d < 4; d++) r.dev[d] = (pg == TBL[mst[g]][d]);
        rb = SWZ[g] ? {rom_data[0], rom_data[6:1], rom_data[7]} : rom_data;
        r.din = 8'hFF;
        if (r.ram) r.din = ram_dout;
        else if (r.dev != 4'b0) begin
            for (int d = 3; d >= 0; d--) if (r.dev[d]) r.din = dev_dout[d*8 +: 8];
        end else if (r.rom) r.din = rb;
        if (pg == CLRP[g]) mst[g] = 0;
        else if (pg == 5'h02 && (!ADVW[g] || !wr_n)) mst[g] = ROTE[g] ? (mst[g] + 1) % 4 : 0;
        r.st = 2'(mst[g]);
    endtask

    task automatic access(input logic [4:0] pg, input logic wr_n, input int k,
                          input logic [7:0] rd, input bit ce_too);
        exp_t e;
        rom_data = rd;
        ram_dout = 8'($urandom);
        dev_dout = $urandom;
        for (int g = 0; g < 4; g++) model(g, pg, wr_n, e.r[g]);
        e.lows = (pg == 5'h00) ? 8'(k) : 8'd0;
        expq.push_back(e);
        @(negedge clk);
        sx = 1'b1; page = pg; wrn = wr_n; ce = ce_too; rom_ok = (k == 0);
        @(negedge clk);
        sx = 1'b0; ce = 1'b0;
        repeat (k) @(negedge clk);
        rom_ok = 1'b1;
        @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk("cs_after_ce", g, {rom_cs_o[g], ram_cs_o[g], dev_cs_o[g]}, 0);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Monitor: an accepted sx is answered once wait_n is high two edges later.
    initial begin
        exp_t e;
        int   lows;
        forever begin
            @(posedge clk);
            if (mon_en && sx) begin
                @(posedge clk);
                @(negedge clk);
                lows = 0;
                while (!wait_o[0] && lows < 50) begin
                    lows++;
                    @(negedge clk);
                end
                if (expq.size() == 0) begin
                    chk("unexpected_response", 0, 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("wait_low_cycles", 0, lows, int'(e.lows));
                    for (int g = 0; g < 4; g++) begin
                        chk("wait_n", g, wait_o[g], 1);
                        chk("rom_cs", g, rom_cs_o[g], e.r[g].rom);
                        chk("ram_cs", g, ram_cs_o[g], e.r[g].ram);
                        chk("dev_cs", g, dev_cs_o[g], e.r[g].dev);
                        chk("din", g, din_o[g], e.r[g].din);
                        chk("map_st", g, st_o[g], e.r[g].st);
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0] pg;
        for (int g = 0; g < 4; g++) mst[g] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("reset_cs", g, {rom_cs_o[g], ram_cs_o[g], dev_cs_o[g]}, 0);
            chk("reset_din", g, din_o[g], 8'hFF);
            chk("reset_wait", g, wait_o[g], 1);
            chk("reset_st", g, st_o[g], 0);
        end
        mon_en = 1'b1;

        access(5'h03, 1'b1, 0, 8'h00, 1'b0);
        access(5'h02, 1'b0, 0, 8'h00, 1'b0);
        access(5'h02, 1'b1, 0, 8'h00, 1'b0);
        access(5'h02, 1'b0, 0, 8'h00, 1'b0);
        access(5'h09, 1'b1, 0, 8'h00, 1'b0);
        access(5'h1F, 1'b1, 0, 8'h00, 1'b0);
        access(5'h02, 1'b0, 0, 8'h00, 1'b0);
        access(5'h02, 1'b1, 0, 8'h00, 1'b0);
        access(5'h02, 1'b0, 0, 8'h00, 1'b0);
        access(5'h03, 1'b1, 0, 8'h00, 1'b0);
        access(5'h00, 1'b1, 5, 8'h81, 1'b0);
        access(5'h00, 1'b1, 2, 8'h5A, 1'b1);
        access(5'h0A, 1'b1, 0, 8'h00, 1'b0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: pg = 5'h00;
                1: pg = 5'h1F;
                2: pg = 5'h02;
                3: pg = 5'h03;
                4: pg = TBL[$urandom_range(0, 3)][$urandom_range(0, 3)];
                default: pg = 5'($urandom);
            endcase
            access(pg, 1'($urandom), $urandom_range(0, 3), 8'($urandom),
                   ($urandom_range(0, 3) == 0));
        end

        access(5'h02, 1'b0, 0, 8'h00, 1'b0);
        access(5'h02, 1'b0, 0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        sx = 1'b1; page = 5'h1F; wrn = 1'b0;
        @(negedge clk);
        sx = 1'b0; rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("midrst_cs", g, {rom_cs_o[g], ram_cs_o[g], dev_cs_o[g]}, 0);
            chk("midrst_st", g, st_o[g], 0);
            chk("midrst_din", g, din_o[g], 8'hFF);
            mst[g] = 0;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("queue_drained", 0, expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
